mux_n_para_1_arb: RTL and testbench

//   Parametrised, registered N:1 multiplexer of WIDTH-bit channels with valid/ready

---
 rtl/mux_n_para_1_arb.sv | 117 +++++++++++
 tb/tb_mux_n_para_1_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mux_n_para_1_arb.sv
// Registered N:1 channel multiplexer with valid/ready handshakes.
// Channel picked by fixed select S or by a rotating round-robin pointer.
module mux_n_para_1_arb #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] D,
   input  logic [N-1:0]       D_VALID,
   output logic [N-1:0]       D_READY,
   input  logic [SEL_W-1:0]   S,
   input  logic               MODE,
   output logic [WIDTH-1:0]   Y,
   output logic               Y_VALID,
   input  logic               Y_READY,
   output logic [SEL_W-1:0]   Y_SEL
);

   logic [WIDTH-1:0] ch [N];

   logic [WIDTH-1:0] y_q;
   logic             y_vld_q;
   logic [SEL_W-1:0] y_sel_q;
   logic [SEL_W-1:0] ptr_q;

   logic             ld;
   logic             fix_vld;
   logic             rr_vld;
   logic [SEL_W-1:0] rr_gnt;
   logic             gnt_vld;
   logic [SEL_W-1:0] gnt;
   logic [SEL_W-1:0] ptr_nxt;
   logic             take;

   for (genvar i = 0; i < N; i++) begin : g_ch
      assign ch[i] = D[i*WIDTH +: WIDTH];
   end

   // The output register can accept a word when empty or
   // when its current word leaves this same cycle.
   assign ld = !y_vld_q | Y_READY;

   // Fixed select: only an in-range S with valid data wins.
   always_comb begin
      fix_vld = 1'b0;
      if (int'(S) < N) begin
         fix_vld = D_VALID[S];
      end
   end

   // Round-robin scan starting at the pointer, wrapping mod N.
   always_comb begin
      int idx;
      logic [SEL_W-1:0] ix;
      idx    = 0;
      ix     = '0;
      rr_vld = 1'b0;
      rr_gnt = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         ix = SEL_W'(idx);
         if (!rr_vld && D_VALID[ix]) begin
            rr_vld = 1'b1;
            rr_gnt = ix;
         end
      end
   end

   assign gnt_vld = MODE ? rr_vld : fix_vld;
   assign gnt     = MODE ? rr_gnt : S;
   assign take    = ld & gnt_vld;

   // Pointer moves past the granted channel, wrapping at N-1.
   always_comb begin
      ptr_nxt = gnt + 1'b1;
      if (int'(gnt) == N - 1) begin
         ptr_nxt = '0;
      end
   end

   // One-hot ready to the granted channel; silent during reset.
   always_comb begin
      D_READY = '0;
      if (!rst && take) begin
         D_READY[gnt] = 1'b1;
      end
   end

   // Output register: refill on grant, else drain when taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q     <= '0;
         y_vld_q <= 1'b0;
         y_sel_q <= '0;
         ptr_q   <= '0;
      end else if (take) begin
         y_q     <= ch[gnt];
         y_sel_q <= gnt;
         y_vld_q <= 1'b1;
         if (MODE) begin
            ptr_q <= ptr_nxt;
         end
      end else if (Y_READY) begin
         y_vld_q <= 1'b0;
      end
   end

   assign Y       = y_q;
   assign Y_VALID = y_vld_q;
   assign Y_SEL   = y_sel_q;

endmodule

// File: tb/tb_mux_n_para_1_arb.sv
// Directed bench for mux_n_para_1_arb.
// Covers a 4-channel build and a 3-channel build with invalid select.
module tb_mux_n_para_1_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [31:0] d_a = {8'h44, 8'hA5, 8'h22, 8'h11};
   logic [3:0]  dv_a = '0;
   logic [3:0]  dr_a;
   logic [1:0]  s_a = '0;
   logic        m_a = 1'b0;
   logic [7:0]  y_a;
   logic        yv_a;
   logic        yr_a = 1'b0;
   logic [1:0]  ys_a;

   logic [23:0] d_b = {8'h33, 8'h22, 8'h11};
   logic [2:0]  dv_b = '0;
   logic [2:0]  dr_b;
   logic [1:0]  s_b = '0;
   logic        m_b = 1'b0;
   logic [7:0]  y_b;
   logic        yv_b;
   logic        yr_b = 1'b0;
   logic [1:0]  ys_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_n_para_1_arb #(.WIDTH(8), .N(4), .SEL_W(2)) dut_a (
      .clk(clk), .rst(rst), .D(d_a), .D_VALID(dv_a),
      .D_READY(dr_a), .S(s_a), .MODE(m_a), .Y(y_a),
      .Y_VALID(yv_a), .Y_READY(yr_a), .Y_SEL(ys_a)
   );

   mux_n_para_1_arb #(.WIDTH(8), .N(3), .SEL_W(2)) dut_b (
      .clk(clk), .rst(rst), .D(d_b), .D_VALID(dv_b),
      .D_READY(dr_b), .S(s_b), .MODE(m_b), .Y(y_b),
      .Y_VALID(yv_b), .Y_READY(yr_b), .Y_SEL(ys_b)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic out_a(input string tag,
                        input logic [7:0] y,
                        input logic [1:0] sel,
                        input logic v);
      chk({tag, ".y"}, 32'(y_a), 32'(y));
      chk({tag, ".sel"}, 32'(ys_a), 32'(sel));
      chk({tag, ".vld"}, 32'(yv_a), 32'(v));
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #3;
      out_a("rst0", 8'h00, 2'd0, 1'b0);
      chk("rst0.rdy", 32'(dr_a), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Fixed select S=2
      m_a = 1'b0; s_a = 2'd2; dv_a = 4'hF; yr_a = 1'b1;
      #1;
      chk("fix.rdy", 32'(dr_a), 32'b0100);
      step();
      out_a("fix", 8'hA5, 2'd2, 1'b1);

      // Round-robin, all valid: 0,1,2,3,0
      m_a = 1'b1;
      #1;
      chk("rr0.rdy", 32'(dr_a), 32'b0001);
      step();
      out_a("rr0", 8'h11, 2'd0, 1'b1);
      #1;
      chk("rr1.rdy", 32'(dr_a), 32'b0010);
      step();
      out_a("rr1", 8'h22, 2'd1, 1'b1);
      step();
      out_a("rr2", 8'hA5, 2'd2, 1'b1);
      step();
      out_a("rr3", 8'h44, 2'd3, 1'b1);
      step();
      out_a("rr4", 8'h11, 2'd0, 1'b1);

      // Skip: ptr=1, valid 1001 -> ch3 then ch0
      dv_a = 4'b1001;
      #1;
      chk("skip0.rdy", 32'(dr_a), 32'b1000);
      step();
      out_a("skip0", 8'h44, 2'd3, 1'b1);
      #1;
      chk("skip1.rdy", 32'(dr_a), 32'b0001);
      step();
      out_a("skip1", 8'h11, 2'd0, 1'b1);

      // Backpressure for 3 cycles
      dv_a = 4'hF; yr_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp.rdy", 32'(dr_a), 32'h0);
         step();
         out_a("bp", 8'h11, 2'd0, 1'b1);
      end
      // Drain and refill in one cycle from ch1
      dv_a = 4'b0010; yr_a = 1'b1;
      #1;
      chk("refill.rdy", 32'(dr_a), 32'b0010);
      step();
      out_a("refill", 8'h22, 2'd1, 1'b1);

      // Fixed grant must leave ptr (now 2) alone
      m_a = 1'b0; s_a = 2'd3; dv_a = 4'hF;
      step();
      out_a("fix3", 8'h44, 2'd3, 1'b1);
      m_a = 1'b1;
      #1;
      chk("keep.rdy", 32'(dr_a), 32'b0100);
      step();
      out_a("keep", 8'hA5, 2'd2, 1'b1);

      // No valid data: drain, Y and Y_SEL hold
      dv_a = 4'h0;
      #1;
      chk("idle.rdy", 32'(dr_a), 32'h0);
      step();
      out_a("drain", 8'hA5, 2'd2, 1'b0);

      // Reset mid-stream with a full register
      dv_a = 4'hF; yr_a = 1'b0;
      step();
      out_a("pre", 8'h44, 2'd3, 1'b1);
      #1;
      rst = 1'b1; yr_a = 1'b1;
      #1;
      out_a("arst", 8'h00, 2'd0, 1'b0);
      chk("arst.rdy", 32'(dr_a), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post.rdy", 32'(dr_a), 32'b0001);
      step();
      out_a("post", 8'h11, 2'd0, 1'b1);

      // 3-channel build: load ch1, then invalid S=3
      m_b = 1'b0; s_b = 2'd1; dv_b = 3'b111; yr_b = 1'b1;
      #1;
      chk("n3.rdy", 32'(dr_b), 32'b010);
      step();
      chk("n3.y", 32'(y_b), 32'h22);
      chk("n3.vld", 32'(yv_b), 32'h1);
      s_b = 2'd3; yr_b = 1'b0;
      #1;
      chk("n3s.rdy", 32'(dr_b), 32'h0);
      step();
      chk("n3s.vld", 32'(yv_b), 32'h1);
      yr_b = 1'b1;
      #1;
      chk("n3bad.rdy", 32'(dr_b), 32'h0);
      step();
      chk("n3bad.vld", 32'(yv_b), 32'h0);
      chk("n3bad.y", 32'(y_b), 32'h22);
      chk("n3bad.sel", 32'(ys_b), 32'h1);
      #1;
      chk("n3e.rdy", 32'(dr_b), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
